// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier scheduler: state encoding and
// the default operand width.
package mult_pkg;
   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright; on contention the
// requester that was not served last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_served,
   output logic       winner
);
   always_comb begin
      case (req)
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_served;
         default: winner = 1'b0;
      endcase
   end
endmodule

// File: rtl/mult_sched.sv
// Control sequencer for a shared shift-add multiplier serving two requesters:
// arbitrates, issues load/add/shift strobes per multiplier bit, then pulses done.
module mult_sched
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       m,
   output logic       sel,
   output logic       load,
   output logic       ad,
   output logic       sh,
   output logic       idle,
   output logic [1:0] done
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_owner;
   logic            r_last_served;
   logic            w_winner;
   logic            w_last_bit;
   logic            w_in_idle;

   rr_arb2 u_arb (
      .req         (req),
      .last_served (r_last_served),
      .winner      (w_winner)
   );

   assign w_last_bit = (r_cnt == C_LAST);
   assign w_in_idle  = (r_state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_owner       <= 1'b0;
         r_last_served <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req != 2'b00) begin
                  r_owner <= w_winner;
                  r_cnt   <= '0;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (m) begin
                  r_state <= S_SHIFT;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_state <= w_last_bit ? S_DONE : S_CHECK;
               end
            end
            S_SHIFT: begin
               r_cnt   <= r_cnt + CW'(1);
               r_state <= w_last_bit ? S_DONE : S_CHECK;
            end
            default: begin
               r_last_served <= r_owner;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   // Grant is visible in the load cycle itself, so IDLE outputs follow the arbiter.
   assign idle = w_in_idle;
   assign load = w_in_idle & (req != 2'b00) & rst_n;
   assign sel  = w_in_idle ? w_winner : r_owner;
   assign ad   = (r_state == S_CHECK) & m;
   assign sh   = ((r_state == S_CHECK) & ~m) | (r_state == S_SHIFT);
   assign done = (r_state == S_DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a transaction-level expectation model and
// a small multiplier-register model that feeds back the m bit.
module tb_mult_sched;
   localparam int W = 4;
   localparam int C_AD = 1, C_SH = 2, C_DONE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic       m;
   logic       sel, load, ad, sh, idle;
   logic [1:0] done;

   always #5 clk = ~clk;

   mult_sched #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .m     (m),
      .sel   (sel),
      .load  (load),
      .ad    (ad),
      .sh    (sh),
      .idle  (idle),
      .done  (done)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [W-1:0] mult_val [2];
   logic [W-1:0] mreg = '0;
   assign m = mreg[0];

   int   q[$];
   logic mdl_owner = 1'b0;
   logic mdl_last  = 1'b1;
   int   load_cyc[$];
   int   load_sel[$];
   int   done_cyc[$];
   int   done_idx[$];
   int   n_ad = 0;
   int   n_done = 0;
   logic cap_load = 1'b0, cap_sh = 1'b0, cap_sel = 1'b0;

   function automatic logic rr(input logic [1:0] r, input logic last);
      if (r == 2'b11) return ~last;
      return (r == 2'b10);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the expected strobe stream.
   initial begin
      logic       e_idle, e_load, e_ad, e_sh, e_sel;
      logic [1:0] e_done;
      int         code;
      forever begin
         @(negedge clk);
         cyc++;
         e_idle = 1'b1; e_load = 1'b0; e_ad = 1'b0; e_sh = 1'b0; e_done = 2'b00;
         if (!rst_n) begin
            q.delete();
            mdl_last = 1'b1;
            e_sel = rr(req, 1'b1);
         end else if (q.size() == 0) begin
            e_sel  = rr(req, mdl_last);
            e_load = (req != 2'b00);
            if (e_load) begin
               mdl_owner = e_sel;
               for (int b = 0; b < W; b++) begin
                  if (mult_val[e_sel][b]) q.push_back(C_AD);
                  q.push_back(C_SH);
               end
               q.push_back(C_DONE);
            end
         end else begin
            code   = q.pop_front();
            e_idle = 1'b0;
            e_sel  = mdl_owner;
            e_ad   = (code == C_AD);
            e_sh   = (code == C_SH);
            if (code == C_DONE) begin
               e_done   = mdl_owner ? 2'b10 : 2'b01;
               mdl_last = mdl_owner;
            end
         end
         chk("idle", idle, e_idle);
         chk("load", load, e_load);
         chk("ad",   ad,   e_ad);
         chk("sh",   sh,   e_sh);
         chk("sel",  sel,  e_sel);
         chk("done", done, e_done);
         if (load) begin
            load_cyc.push_back(cyc);
            load_sel.push_back(int'(sel));
         end
         if (ad) n_ad++;
         if (done != 2'b00) begin
            done_cyc.push_back(cyc);
            done_idx.push_back(int'(done[1]));
            n_done++;
            $display("op done: requester %0d at cycle %0d", done[1], cyc);
         end
         cap_load = load; cap_sh = sh; cap_sel = sel;
      end
   end

   // Multiplier register of the datapath: loaded on load, shifted right on sh.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cap_load)    mreg = mult_val[cap_sel];
         else if (cap_sh) mreg = mreg >> 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int idx, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done[idx]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_done", ok, 1);
   endtask

   initial begin
      int lb, db, ab, nd0;
      mult_val[0] = '0;
      mult_val[1] = '0;

      // Idle after reset, no requests.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) tick();
      chk("c031_no_load", load_cyc.size(), 0);
      chk("c031_no_done", n_done, 0);

      // Both requesting: 0,1,0 with back-to-back loads.
      mult_val[0] = 4'b0101;
      mult_val[1] = 4'b0011;
      lb = load_cyc.size(); db = done_cyc.size();
      req = 2'b11;
      wait_done(0, 40);
      wait_done(1, 40);
      wait_done(0, 40);
      tick();
      req = 2'b00;
      chk("c034_nloads", load_cyc.size() - lb, 3);
      chk("c034_ndones", done_cyc.size() - db, 3);
      chk("c034_sel0", load_sel[lb], 0);
      chk("c034_sel1", load_sel[lb+1], 1);
      chk("c034_sel2", load_sel[lb+2], 0);
      chk("c034_done1", done_idx[db+1], 1);
      chk("c034_b2b1", load_cyc[lb+1], done_cyc[db] + 1);
      chk("c034_b2b2", load_cyc[lb+2], done_cyc[db+1] + 1);
      chk("c034_lat0", done_cyc[db] - load_cyc[lb] + 1, 8);

      // Multiplier 1011 on requester 0.
      tick();
      mult_val[0] = 4'b1011;
      lb = load_cyc.size(); db = done_cyc.size(); ab = n_ad;
      req = 2'b01;
      wait_done(0, 40);
      tick();
      req = 2'b00;
      chk("c032_lat", done_cyc[db] - load_cyc[lb] + 1, 9);
      chk("c032_sel", load_sel[lb], 0);
      chk("c032_nad", n_ad - ab, 3);

      // Multiplier 0000.
      tick();
      mult_val[0] = 4'b0000;
      lb = load_cyc.size(); db = done_cyc.size(); ab = n_ad;
      req = 2'b01;
      wait_done(0, 40);
      tick();
      req = 2'b00;
      chk("c033_lat", done_cyc[db] - load_cyc[lb] + 1, 6);
      chk("c033_nad", n_ad - ab, 0);

      // Requests change during requester 0's operation.
      tick();
      mult_val[0] = 4'b1011;
      mult_val[1] = 4'b0110;
      lb = load_cyc.size(); db = done_cyc.size();
      req = 2'b01;
      repeat (3) tick();
      req = 2'b11;
      repeat (2) tick();
      req = 2'b10;
      wait_done(0, 40);
      wait_done(1, 40);
      tick();
      req = 2'b00;
      chk("c035_done0", done_idx[db], 0);
      chk("c035_sel_next", load_sel[lb+1], 1);
      chk("c035_b2b", load_cyc[lb+1], done_cyc[db] + 1);
      chk("c035_lat1", done_cyc[db+1] - load_cyc[lb+1] + 1, 8);

      // Asynchronous reset in the middle of a SHIFT cycle.
      tick();
      mult_val[0] = 4'b1111;
      mult_val[1] = 4'b0001;
      nd0 = n_done;
      req = 2'b01;
      repeat (3) @(negedge clk);
      #2;
      chk("c036_in_shift", sh, 1);
      rst_n = 1'b0;
      req = 2'b11;
      #1;
      chk("c036_rst_idle", idle, 1);
      chk("c036_rst_sh", sh, 0);
      chk("c036_rst_load", load, 0);
      chk("c036_rst_done", done, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("c036_no_done", n_done, nd0);
      lb = load_cyc.size(); db = done_cyc.size();
      wait_done(0, 40);
      tick();
      req = 2'b00;
      chk("c036_sel", load_sel[lb], 0);
      chk("c036_lat", done_cyc[db] - load_cyc[lb] + 1, 10);
      chk("c036_ndone", n_done, nd0 + 1);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
